// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the mini-MIPS multi-cycle sequencer: states, opcodes,
// ALU control codes, error codes and small decode helpers.
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_TRAP
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_ADDI = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_ADDI: return 1'b1;
         default:                                                return is_branch(op);
      endcase
   endfunction

   function automatic logic [3:0] alu_ctl_of(input logic [3:0] op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB:          return ALU_SUB;
         OP_AND:          return ALU_AND;
         OP_OR:           return ALU_OR;
         OP_NOR:          return ALU_NOR;
         OP_SLT:          return ALU_SLT;
         OP_BEQ, OP_BNE:  return ALU_SUB;
         default:         return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch side of the sequencer: req/ack handshake, IR load strobe
// and the opcode field fed back from the IR.
interface cpu_sequencer_if;
   logic       imem_req;
   logic       imem_ack;
   logic       ir_write;
   logic [3:0] opcode;

   modport master (output imem_req, output ir_write, input imem_ack, input opcode);
   modport slave  (input imem_req, input ir_write, output imem_ack, output opcode);
endinterface

// File: rtl/cpu_sequencer_fetch_timer.sv
// 8-bit wait-cycle counter for the fetch handshake; holds once it reaches LIMIT.
module cpu_sequencer_fetch_timer #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [7:0] count;

   assign expired = (count == LIMIT[7:0]);

   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 8'd1;
   end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit mini-MIPS datapath: fetch handshake,
// decode, execute, writeback, run/step control and sticky error trap.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int unsigned FETCH_TIMEOUT = 15,
   parameter int unsigned CNT_W         = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   cpu_sequencer_if.master    imem,
   input  logic               zero,
   output logic               pc_write,
   output logic               pc_src,
   output logic               reg_dst,
   output logic               alu_src,
   output logic               reg_write,
   output logic [3:0]         alu_ctl,
   output logic               busy,
   output logic               trap,
   output logic [1:0]         err_code,
   output logic [CNT_W-1:0]   retired
);
   state_t     state, next_state;
   logic       one_shot, next_one_shot;
   logic [1:0] next_err;
   logic [3:0] op_q;
   logic       retire;
   logic       timer_clear, timer_en, timer_expired;

   cpu_sequencer_fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_fetch_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         one_shot <= 1'b0;
         err_code <= ERR_NONE;
         op_q     <= '0;
         retired  <= '0;
      end else begin
         state    <= next_state;
         one_shot <= next_one_shot;
         err_code <= next_err;
         if (state == S_DECODE)
            op_q <= imem.opcode;
         if (retire)
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      next_state     = state;
      next_one_shot  = one_shot;
      next_err       = err_code;
      retire         = 1'b0;
      timer_clear    = 1'b1;
      timer_en       = 1'b0;
      imem.imem_req  = 1'b0;
      imem.ir_write  = 1'b0;
      pc_write       = 1'b0;
      pc_src         = 1'b0;
      reg_dst        = 1'b0;
      alu_src        = 1'b0;
      reg_write      = 1'b0;
      alu_ctl        = '0;
      busy           = (state != S_IDLE) && (state != S_TRAP);
      trap           = (state == S_TRAP);

      case (state)
         S_IDLE: begin
            if (run || step) begin
               next_state    = S_FETCH;
               next_one_shot = step && !run;
            end
         end
         S_FETCH: begin
            imem.imem_req = 1'b1;
            timer_clear   = 1'b0;
            timer_en      = 1'b1;
            // ack is checked first so an ack in the expiry cycle still completes the fetch
            if (imem.imem_ack) begin
               imem.ir_write = 1'b1;
               next_state    = S_DECODE;
            end else if (timer_expired) begin
               next_err   = ERR_TIMEOUT;
               next_state = S_TRAP;
            end
         end
         S_DECODE: begin
            if (is_legal(imem.opcode)) begin
               next_state = S_EXEC;
            end else begin
               next_err   = ERR_ILLEGAL;
               next_state = S_TRAP;
            end
         end
         S_EXEC, S_WB: begin
            alu_ctl = alu_ctl_of(op_q);
            if (is_branch(op_q)) begin
               pc_write = 1'b1;
               pc_src   = (op_q == OP_BEQ) ? zero : !zero;
               retire   = 1'b1;
            end else begin
               reg_dst = (op_q != OP_ADDI);
               alu_src = (op_q == OP_ADDI);
               if (state == S_WB) begin
                  reg_write = 1'b1;
                  pc_write  = 1'b1;
                  retire    = 1'b1;
               end else begin
                  next_state = S_WB;
               end
            end
            if (retire) begin
               if (run && !one_shot) begin
                  next_state = S_FETCH;
               end else begin
                  next_state    = S_IDLE;
                  next_one_shot = 1'b0;
               end
            end
         end
         S_TRAP: begin
         end
         default: next_state = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table-driven instruction stream with
// a strobe scoreboard, plus directed sequences for step, trap and reset cases.
module tb_cpu_sequencer;

   typedef struct packed {
      logic [3:0] alu;
      logic       dst;
      logic       src;
      logic       pcsrc;
      logic       regw;
      logic       pcw;
   } out_t;

   typedef struct {
      logic [3:0] op;
      logic       zero;
      int         delay;
      out_t       exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        run   = 1'b0;
   logic        step  = 1'b0;
   logic        zero  = 1'b0;
   logic        pc_write, pc_src, reg_dst, alu_src, reg_write, busy, trap;
   logic [3:0]  alu_ctl;
   logic [1:0]  err_code;
   logic [15:0] retired;

   logic        pc_write4, pc_src4, reg_dst4, alu_src4, reg_write4, busy4, trap4;
   logic [3:0]  alu_ctl4;
   logic [1:0]  err_code4;
   logic [3:0]  retired4;

   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   n_regw = 0;
   int   cyc    = 0;
   out_t exp_q[$];
   vec_t v[17];

   cpu_sequencer_if bus();
   cpu_sequencer_if bus4();

   assign bus4.imem_ack = bus.imem_ack;
   assign bus4.opcode   = bus.opcode;

   cpu_sequencer #(.FETCH_TIMEOUT(15), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .run(run), .step(step), .imem(bus.master), .zero(zero),
      .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .alu_src(alu_src),
      .reg_write(reg_write), .alu_ctl(alu_ctl), .busy(busy), .trap(trap),
      .err_code(err_code), .retired(retired)
   );

   cpu_sequencer #(.FETCH_TIMEOUT(15), .CNT_W(4)) dut4 (
      .clock(clock), .reset(reset), .run(run), .step(step), .imem(bus4.master), .zero(zero),
      .pc_write(pc_write4), .pc_src(pc_src4), .reg_dst(reg_dst4), .alu_src(alu_src4),
      .reg_write(reg_write4), .alu_ctl(alu_ctl4), .busy(busy4), .trap(trap4),
      .err_code(err_code4), .retired(retired4)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Strobe scoreboard: every reg_write/pc_write pulse must match the next queued expectation
   always @(negedge clock) begin
      if (reg_write || pc_write) begin
         if (reg_write) n_regw++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_unexpected: got rw=%b pw=%b expected none (cycle %0d)",
                     reg_write, pc_write, cyc);
         end else begin
            check("strobe", {alu_ctl, reg_dst, alu_src, pc_src, reg_write, pc_write}, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_vec(input int i, input logic [3:0] op, input logic z, input int d,
                          input logic [3:0] alu, input logic dst, input logic src,
                          input logic pcsrc, input logic regw);
      v[i].op    = op;
      v[i].zero  = z;
      v[i].delay = d;
      v[i].exp   = {alu, dst, src, pcsrc, regw, 1'b1};
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      step  = 1'b0;
      bus.imem_ack = 1'b0;
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic all_quiet(input string name);
      check(name, {bus.imem_req, bus.ir_write, pc_write, pc_src, reg_dst, alu_src, reg_write,
                   alu_ctl, busy, trap, err_code, retired}, 64'd0);
   endtask

   // Serve one fetch for vector i and wait for it to retire; optionally drop run during EXEC
   task automatic run_vec(input int i, input bit drop);
      int          c0;
      int          n;
      logic [15:0] r0;
      n = 0;
      while (!bus.imem_req && n < 8) begin
         tick();
         n++;
      end
      check("req_seen", bus.imem_req, 1);
      c0 = cyc;
      r0 = retired;
      repeat (v[i].delay) tick();
      bus.imem_ack = 1'b1;
      bus.opcode   = v[i].op;
      zero         = v[i].zero;
      exp_q.push_back(v[i].exp);
      tick();
      bus.imem_ack = 1'b0;
      if (drop) begin
         tick();
         run = 1'b0;
      end
      n = 0;
      while (retired == r0 && n < 40) begin
         tick();
         n++;
      end
      check("latency", cyc - c0, v[i].delay + (v[i].exp.regw ? 4 : 3));
      check("retired_inc", retired, r0 + 16'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1);
   end

   initial begin
      int c_start;
      bus.imem_ack = 1'b0;
      bus.opcode   = 4'b0000;

      set_vec( 0, 4'b0111, 1'b0,  0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1);
      set_vec( 1, 4'b0111, 1'b0,  0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1);
      set_vec( 2, 4'b0010, 1'b0,  0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec( 3, 4'b0001, 1'b0,  0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec( 4, 4'b0011, 1'b0,  0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec( 5, 4'b0000, 1'b0,  0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec( 6, 4'b0100, 1'b0,  0, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec( 7, 4'b0110, 1'b0,  0, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec( 8, 4'b0110, 1'b0,  0, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec( 9, 4'b1000, 1'b1,  0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
      set_vec(10, 4'b1001, 1'b1,  0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
      set_vec(11, 4'b1000, 1'b0,  0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
      set_vec(12, 4'b1001, 1'b0,  0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
      set_vec(13, 4'b0111, 1'b0, 15, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1);
      set_vec(14, 4'b0001, 1'b0,  3, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1);
      set_vec(15, 4'b1000, 1'b1,  1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
      set_vec(16, 4'b0000, 1'b0,  0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);

      repeat (2) tick();
      all_quiet("reset_state");
      reset = 1'b0;

      // Continuous run over the whole table; run drops during EXEC of the last entry
      run = 1'b1;
      tick();
      c_start = cyc;
      for (int i = 0; i < 17; i++) begin
         run_vec(i, i == 16);
         if (i == 8) begin
            check("cycles_first9", cyc - c_start, 36);
            check("retired_first9", retired, 9);
            check("regw_first9", n_regw, 9);
         end
      end
      repeat (3) tick();
      check("retired_17", retired, 17);
      check("retired_wrap_cnt4", retired4, 4'd1);
      check("idle_after_run_drop", {busy, bus.imem_req}, 2'b00);
      check("regw_total", n_regw, 12);
      check("scoreboard_empty", exp_q.size(), 0);

      // Single step executes exactly one instruction
      do_reset();
      step = 1'b1;
      tick();
      step = 1'b0;
      run_vec(0, 1'b0);
      repeat (3) tick();
      check("step_back_idle", {busy, bus.imem_req}, 2'b00);
      check("step_retired", retired, 1);

      // run and step together behave as run
      run  = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      run_vec(2, 1'b0);
      check("run_step_continues", bus.imem_req, 1);
      run_vec(5, 1'b1);
      repeat (2) tick();
      check("run_step_idle", {busy, retired}, {1'b0, 16'd3});

      // Reset in EXEC aborts the instruction
      do_reset();
      run = 1'b1;
      tick();
      bus.imem_ack = 1'b1;
      bus.opcode   = 4'b0000;
      tick();
      bus.imem_ack = 1'b0;
      tick();
      check("in_exec_busy", busy, 1);
      reset = 1'b1;
      tick();
      all_quiet("reset_in_exec");
      reset = 1'b0;
      run   = 1'b0;
      tick();
      all_quiet("after_abort_idle");

      // Illegal opcode traps without writes
      do_reset();
      run = 1'b1;
      tick();
      bus.imem_ack = 1'b1;
      bus.opcode   = 4'b0101;
      tick();
      bus.imem_ack = 1'b0;
      run = 1'b0;
      tick();
      check("illegal_trap", {trap, busy, err_code}, 4'b1001);
      repeat (3) tick();
      check("illegal_retired", retired, 0);

      // Fetch timeout: no ack ever
      do_reset();
      run = 1'b1;
      tick();
      repeat (15) tick();
      check("timeout_still_fetch", {trap, bus.imem_req}, 2'b01);
      tick();
      check("timeout_trap", {trap, busy, err_code}, 4'b1010);
      step = 1'b1;
      bus.imem_ack = 1'b1;
      repeat (2) tick();
      step = 1'b0;
      bus.imem_ack = 1'b0;
      run = 1'b0;
      tick();
      check("trap_sticky", {trap, busy, bus.imem_req, err_code, retired}, {3'b100, 2'b10, 16'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
